// File: rtl/memoria_datos_rv32i_pkg.sv
// Shared encodings for the rv32i data-memory responder: funct3 access sizes and FSM states.
package rv32i_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ESPERA    = 2'd1,
        RESPUESTA = 2'd2
    } estado_t;

endpackage

// File: rtl/memoria_datos_rv32i_alineador_carga.sv
// Load aligner: selects byte/half/word lane from the raw word and sign/zero-extends it.
// Purely combinational; also flags halfword/word accesses that are not naturally aligned.
module alineador_carga
    import rv32i_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_data = i_word;
            F3_BU:   o_data = {24'd0, w_byte};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = '0;
        endcase
        o_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    end

endmodule

// File: rtl/memoria_datos_rv32i.sv
// Data memory for the rv32i load/store port: one request at a time, WAIT_STATES extra cycles,
// then a one-cycle Ready (with Error on rejected requests). Strobes are ignored while in ESPERA.
module memoria_datos_rv32i
    import rv32i_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    input  logic        i_mem_write,
    input  logic        i_mem_read,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_read_data,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_error
);

    localparam int         AW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [31:0] r_mem [DEPTH_WORDS];

    estado_t     r_state, w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_f3;
    logic        r_wr, r_rd, r_err;

    logic        w_accept, w_enter_resp, w_commit, w_load;
    logic [31:0] w_act_addr, w_act_wdata, w_word, w_ld_data, w_wlanes;
    logic [2:0]  w_act_f3;
    logic        w_act_wr, w_act_rd, w_misal, w_oor, w_bad_f3, w_err;
    logic [3:0]  w_be;
    logic [AW-1:0] w_idx;

    assign w_accept     = (r_state != ESPERA) && (i_mem_write || i_mem_read);
    assign w_enter_resp = (w_accept && (WAIT_STATES == 0)) || ((r_state == ESPERA) && (r_cnt == 4'd0));

    // With no wait states the request commits on its own capture edge, so decode the live inputs.
    assign w_act_addr  = (WAIT_STATES == 0) ? i_address    : r_addr;
    assign w_act_wdata = (WAIT_STATES == 0) ? i_write_data : r_wdata;
    assign w_act_f3    = (WAIT_STATES == 0) ? i_funct3     : r_f3;
    assign w_act_wr    = (WAIT_STATES == 0) ? i_mem_write  : r_wr;
    assign w_act_rd    = (WAIT_STATES == 0) ? i_mem_read   : r_rd;

    assign w_idx  = w_act_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_oor  = |w_act_addr[31:AW+2];

    alineador_carga u_alineador (
        .i_word       (w_word),
        .i_addr_lo    (w_act_addr[1:0]),
        .i_funct3     (w_act_f3),
        .o_data       (w_ld_data),
        .o_misaligned (w_misal)
    );

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_act_wdata;
        w_bad_f3 = 1'b0;
        if (w_act_wr) begin
            case (w_act_f3)
                F3_B:    begin w_be = 4'b0001 << w_act_addr[1:0];           w_wlanes = {4{w_act_wdata[7:0]}};  end
                F3_H:    begin w_be = 4'b0011 << {w_act_addr[1], 1'b0};     w_wlanes = {2{w_act_wdata[15:0]}}; end
                F3_W:    w_be = 4'b1111;
                default: w_bad_f3 = 1'b1;
            endcase
        end else begin
            w_bad_f3 = !(w_act_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        w_err = (w_act_wr && w_act_rd) || w_oor || w_misal || w_bad_f3;
    end

    assign w_commit = i_reset && w_enter_resp && w_act_wr && !w_err;
    assign w_load   = w_enter_resp && w_act_rd && !w_err;

    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        o_busy  = 1'b0;
        o_ready = 1'b0;
        case (r_state)
            IDLE, RESPUESTA: begin
                o_ready = (r_state == RESPUESTA);
                if (w_accept) w_next = (WAIT_STATES == 0) ? RESPUESTA : ESPERA;
                else          w_next = IDLE;
            end
            ESPERA: begin
                o_busy = 1'b1;
                if (r_cnt == 4'd0) w_next = RESPUESTA;
            end
            default: w_next = IDLE;
        endcase
        o_error = o_ready && r_err;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_address;
                r_wdata <= i_write_data;
                r_f3    <= i_funct3;
                r_wr    <= i_mem_write;
                r_rd    <= i_mem_read;
                r_cnt   <= WS_M1;
            end else if ((r_state == ESPERA) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) r_err   <= w_err;
            if (w_load)       r_rdata <= w_ld_data;
        end
    end

    assign o_read_data = r_rdata;

endmodule

// File: tb/tb_memoria_datos_rv32i.sv
// Bench for memoria_datos_rv32i: a WAIT_STATES=1 instance driven from a vector table plus
// hand sequences, and a WAIT_STATES=0 instance for back-to-back service.
module tb_memoria_datos_rv32i;

    logic        clk, rst_n;
    logic [31:0] ad, wd, rdat;
    logic        mw, mr, rdy, bsy, err_o;
    logic [2:0]  f3s;

    logic [31:0] z_ad, z_wd, z_rdat;
    logic        z_mw, z_mr, z_rdy, z_bsy, z_err;
    logic [2:0]  z_f3;

    int n_checks = 0;
    int n_fail   = 0;

    memoria_datos_rv32i #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_address(ad), .i_write_data(wd),
        .i_mem_write(mw), .i_mem_read(mr), .i_funct3(f3s),
        .o_read_data(rdat), .o_ready(rdy), .o_busy(bsy), .o_error(err_o)
    );

    memoria_datos_rv32i #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_address(z_ad), .i_write_data(z_wd),
        .i_mem_write(z_mw), .i_mem_read(z_mr), .i_funct3(z_f3),
        .o_read_data(z_rdat), .o_ready(z_rdy), .o_busy(z_bsy), .o_error(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic wr, input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic e, output logic [31:0] r);
        @(negedge clk);
        mw = wr; mr = rd; f3s = f3; ad = addr; wd = wdata;
        @(posedge clk);
        #1;
        mw = 1'b0; mr = 1'b0;
        lat = 0; e = 1'b0; r = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rdy) begin
                lat = i; e = err_o; r = rdat;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout addr=%h actual=no_ready required=ready", addr);
        end
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] r;

        //              wr    rd    f3      addr          wdata          err   chk   exp ReadData
        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h20,       32'h12345678, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 3'b010, 32'h20,       32'h0,        1'b0, 1'b1, 32'h12345678};
        tbl[2]  = '{1'b1, 1'b0, 3'b000, 32'h21,       32'hFFFFFF80, 1'b0, 1'b1, 32'h12345678};
        tbl[3]  = '{1'b0, 1'b1, 3'b000, 32'h21,       32'h0,        1'b0, 1'b1, 32'hFFFFFF80};
        tbl[4]  = '{1'b0, 1'b1, 3'b100, 32'h21,       32'h0,        1'b0, 1'b1, 32'h00000080};
        tbl[5]  = '{1'b0, 1'b1, 3'b010, 32'h20,       32'h0,        1'b0, 1'b1, 32'h12348078};
        tbl[6]  = '{1'b1, 1'b0, 3'b001, 32'h22,       32'hCAFEBEEF, 1'b0, 1'b1, 32'h12348078};
        tbl[7]  = '{1'b0, 1'b1, 3'b001, 32'h22,       32'h0,        1'b0, 1'b1, 32'hFFFFBEEF};
        tbl[8]  = '{1'b0, 1'b1, 3'b101, 32'h22,       32'h0,        1'b0, 1'b1, 32'h0000BEEF};
        tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h20,       32'h0,        1'b0, 1'b1, 32'hBEEF8078};
        tbl[10] = '{1'b0, 1'b1, 3'b000, 32'h23,       32'h0,        1'b0, 1'b1, 32'hFFFFFFBE};
        tbl[11] = '{1'b0, 1'b1, 3'b101, 32'h20,       32'h0,        1'b0, 1'b1, 32'h00008078};
        tbl[12] = '{1'b0, 1'b1, 3'b010, 32'h22,       32'h0,        1'b1, 1'b1, 32'h00008078};
        tbl[13] = '{1'b1, 1'b0, 3'b001, 32'h23,       32'h5555,     1'b1, 1'b1, 32'h00008078};
        tbl[14] = '{1'b0, 1'b1, 3'b010, 32'h400,      32'h0,        1'b1, 1'b1, 32'h00008078};
        tbl[15] = '{1'b1, 1'b1, 3'b010, 32'h20,       32'h0,        1'b1, 1'b1, 32'h00008078};
        tbl[16] = '{1'b0, 1'b1, 3'b011, 32'h20,       32'h0,        1'b1, 1'b1, 32'h00008078};
        tbl[17] = '{1'b1, 1'b0, 3'b100, 32'h20,       32'h0,        1'b1, 1'b1, 32'h00008078};
        tbl[18] = '{1'b0, 1'b1, 3'b001, 32'h21,       32'h0,        1'b1, 1'b1, 32'h00008078};
        tbl[19] = '{1'b1, 1'b0, 3'b000, 32'h3FF,      32'h000000A5, 1'b0, 1'b1, 32'h00008078};
        tbl[20] = '{1'b0, 1'b1, 3'b100, 32'h3FF,      32'h0,        1'b0, 1'b1, 32'h000000A5};
        tbl[21] = '{1'b0, 1'b1, 3'b010, 32'h20,       32'h0,        1'b0, 1'b1, 32'hBEEF8078};
        tbl[22] = '{1'b0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h0,        1'b1, 1'b1, 32'hBEEF8078};

        rst_n = 1'b0;
        mw = 0; mr = 0; f3s = 0; ad = 0; wd = 0;
        z_mw = 0; z_mr = 0; z_f3 = 0; z_ad = 0; z_wd = 0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'd0, rdy}, 32'd0);
        chk("reset_busy", {31'd0, bsy}, 32'd0);
        chk("reset_error", {31'd0, err_o}, 32'd0);
        chk("reset_rdata", rdat, 32'd0);
        rst_n = 1'b1;

        // Store dropped by a reset that arrives while it is waiting.
        @(negedge clk);
        mw = 1'b1; f3s = 3'b010; ad = 32'h10; wd = 32'hDEADBEEF;
        @(posedge clk);
        #1 mw = 1'b0;
        @(negedge clk);
        chk("espera_busy", {31'd0, bsy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", {31'd0, rdy}, 32'd0);
        chk("midreset_busy", {31'd0, bsy}, 32'd0);
        chk("midreset_error", {31'd0, err_o}, 32'd0);
        chk("midreset_rdata", rdat, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, lat, e, r);
        chk("dropped_lat", lat, 32'd2);
        chk("dropped_err", {31'd0, e}, 32'd0);
        n_checks++;
        if (r === 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL dropped_store actual=%h required=not_deadbeef", r);
        end

        for (int k = 0; k < NV; k++) begin
            do_op(tbl[k].wr, tbl[k].rd, tbl[k].f3, tbl[k].addr, tbl[k].wdata, lat, e, r);
            chk($sformatf("v%0d_lat", k), lat, 32'd2);
            chk($sformatf("v%0d_err", k), {31'd0, e}, {31'd0, tbl[k].exp_err});
            if (tbl[k].chk_rd) chk($sformatf("v%0d_rdata", k), r, tbl[k].exp_rd);
        end

        // Store strobe raised during ESPERA must be ignored; Ready pulses for one cycle only.
        @(negedge clk);
        mr = 1'b1; f3s = 3'b010; ad = 32'h20;
        @(posedge clk);
        #1 mr = 1'b0;
        @(negedge clk);
        chk("ign_busy", {31'd0, bsy}, 32'd1);
        chk("ign_noready", {31'd0, rdy}, 32'd0);
        mw = 1'b1; f3s = 3'b010; ad = 32'h20; wd = 32'h0;
        @(negedge clk);
        chk("ign_ready", {31'd0, rdy}, 32'd1);
        chk("ign_busy_resp", {31'd0, bsy}, 32'd0);
        chk("ign_rdata", rdat, 32'hBEEF8078);
        mw = 1'b0;
        @(negedge clk);
        chk("ready_pulse", {31'd0, rdy}, 32'd0);
        do_op(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, lat, e, r);
        chk("ign_after", r, 32'hBEEF8078);

        // Zero wait states, back-to-back store then load.
        @(negedge clk);
        z_mw = 1'b1; z_f3 = 3'b010; z_ad = 32'h0; z_wd = 32'h11111111;
        @(negedge clk);
        chk("ws0_sw_ready", {31'd0, z_rdy}, 32'd1);
        chk("ws0_sw_error", {31'd0, z_err}, 32'd0);
        chk("ws0_busy", {31'd0, z_bsy}, 32'd0);
        z_mw = 1'b0; z_mr = 1'b1;
        @(negedge clk);
        chk("ws0_lw_ready", {31'd0, z_rdy}, 32'd1);
        chk("ws0_lw_rdata", z_rdat, 32'h11111111);
        z_mr = 1'b0;
        @(negedge clk);
        chk("ws0_idle", {31'd0, z_rdy}, 32'd0);
        z_mr = 1'b1; z_ad = 32'h2;
        @(negedge clk);
        chk("ws0_err_ready", {31'd0, z_rdy}, 32'd1);
        chk("ws0_err_error", {31'd0, z_err}, 32'd1);
        chk("ws0_err_rdata", z_rdat, 32'h11111111);
        z_mr = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
